// File: rtl/pwm_defs_pkg.sv
// Shared PWM definitions: output-generation mode encoding reused by PWM blocks.
package pwm_defs;

   typedef enum logic {
      MODE_SPREAD  = 1'b0,
      MODE_COMPARE = 1'b1
   } pwm_mode_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: double-buffered duty (shadow/active) and registered output.
module pwm_chan
   import pwm_defs::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             wr_i,
   input  logic [WIDTH-1:0] duty_i,
   input  logic             load_i,
   input  logic             run_i,
   input  pwm_mode_e        mode_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic             pwm_o
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic             pwm_q, pwm_d;
   logic             slot_bit;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      shadow_d = wr_i ? duty_i : shadow_q;
      // Loading from shadow_d lets a write on the load edge reach active directly.
      active_d = load_i ? shadow_d : active_q;

      // Last set bit scanned wins, i.e. the duty bit weighted like cnt's MSB slot.
      slot_bit = 1'b0;
      for (int b = 0; b < WIDTH; b++) begin
         if (cnt_i[b]) slot_bit = active_q[b];
      end

      pwm_d = 1'b0;
      if (run_i) begin
         pwm_d = (mode_i == MODE_COMPARE) ? (cnt_i < active_q) : slot_bit;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of CHANNELS PWM outputs sharing one free-running counter, mode latch
// and period-start pulse.
module pwm_bank
   import pwm_defs::*;
#(
   parameter int  CHANNELS = 4,
   parameter int  WIDTH    = 16,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                mode,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_duty,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_tick
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   pwm_mode_e        mode_q, mode_d;
   logic             en_q;
   logic             tick_q, tick_d;
   logic             load;

   always_comb begin
      cnt_d  = enable ? cnt_q + WIDTH'(1) : '0;
      // Idle keeps active/mode tracking the shadow so a restart uses current values.
      load   = ~enable | (cnt_q == CNT_MAX);
      mode_d = load ? pwm_mode_e'(mode) : mode_q;
      tick_d = enable & ((cnt_q == CNT_MAX) | ~en_q);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         mode_q <= MODE_SPREAD;
         en_q   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         en_q   <= enable;
         tick_q <= tick_d;
      end
   end

   assign period_tick = tick_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      pwm_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clock  (clock),
         .rst_n  (rst_n),
         .wr_i   (wr_en && (wr_ch == CH_W'(g))),
         .duty_i (wr_duty),
         .load_i (load),
         .run_i  (enable),
         .mode_i (mode_q),
         .cnt_i  (cnt_q),
         .pwm_o  (pwm_out[g])
      );
   end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent PWM outputs (1..32).
REQ-002 Parameter WIDTH, default 16, duty and counter width in bits (2..16); period is 2^WIDTH clocks.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low (the polarity and synchronicity are fixed).
REQ-005 enable  input  1  1 = counter runs; 0 = bank idle.
REQ-006 mode  input  1  0 = spread (binary-weighted bit-slot), 1 = compare (edge-aligned).
REQ-007 wr_en  input  1  duty write strobe, one write per clock.
REQ-008 wr_ch  input  $clog2(CHANNELS) (min 1)  target channel index.
REQ-009 wr_duty  input  WIDTH  duty value to write.
REQ-010 pwm_out  output  CHANNELS  registered PWM outputs, bit i = channel i.
REQ-011 period_tick  output  1  registered one-clock pulse marking first cycle of each period.

Function
REQ-012 Free-running counter cnt (WIDTH bits) SHALL increment by 1 each clock while enable=1 and wrap from 2^WIDTH-1 to 0.
REQ-013 While enable=0, cnt SHALL be forced to 0, pwm_out SHALL be 0, period_tick SHALL be 0.
REQ-014 Each channel SHALL hold a shadow duty register and an active duty register, both WIDTH bits.
REQ-015 wr_en=1 with wr_ch<CHANNELS SHALL load wr_duty into that channel's shadow on the same edge; wr_ch>=CHANNELS SHALL be ignored.
REQ-016 Boundary: on the edge where enable=1 and cnt=2^WIDTH-1, every active register SHALL load its shadow and the latched mode register SHALL load mode.
REQ-017 Write coinciding with boundary cycle: written value SHALL reach both shadow and active (write wins).
REQ-018 While enable=0, active SHALL follow shadow (including same-cycle writes) and latched mode SHALL follow mode every clock, so a restart uses current values.
REQ-019 Mode or duty changes mid-period SHALL NOT affect pwm_out until next boundary.
REQ-020 Spread mode: next pwm_out[i] = active_i[k], k = index of highest set bit of cnt; cnt=0 -> 0.
REQ-021 Compare mode: next pwm_out[i] = (cnt < active_i), unsigned.
REQ-022 Both modes SHALL yield exactly D high cycles per 2^WIDTH-cycle period for active duty D; D=0 -> constant 0; D=2^WIDTH-1 -> one low cycle per period.
REQ-023 Latency: pwm_out SHALL be registered, reflecting cnt/active/latched mode of the previous cycle (1 clock).
REQ-024 period_tick SHALL be 1 in the cycle after an edge where cnt wrapped to 0 with enable=1, and on the first cycle after enable rises; 0 otherwise.
REQ-025 enable falling mid-period SHALL abort the period; next enable rise SHALL start a fresh period at cnt=0.

Reset
REQ-026 rst_n=0 SHALL immediately clear cnt, all shadow and active registers, latched mode (to spread), pwm_out and period_tick to 0, regardless of clock.
REQ-027 Reset asserted mid-period SHALL discard pending shadow values; first period after release uses duty 0 until written.
REQ-028 Reset release SHALL be treated as synchronous-deassert by upstream; block adds no synchroniser.

Structure
REQ-029 Shared include pwm_defs SHALL hold MODE_SPREAD=0, MODE_COMPARE=1 constants, reused by future PWM blocks.
REQ-030 Sub-module pwm_chan (shadow, active, output logic for one channel, params WIDTH) SHALL be instantiated CHANNELS times via generate; counter, mode latch, period_tick live in pwm_bank.

Verification (CHANNELS=4, WIDTH=4 unless stated)
REQ-031 Reset: rst_n low mid-run with duties 9 -> pwm_out=0, period_tick=0 immediately, no clock needed; after release outputs stay 0.
REQ-032 Duty sweep: all D=0..15 both modes on ch0 -> exactly D high cycles per 16-cycle period; compare mode high cycles contiguous from period start (+1 latency).
REQ-033 Spread pattern: D=8, spread -> high on cycles where previous cnt in 8..15; D=1 -> high only after cnt=1.
REQ-034 Double buffer: write 12 to ch2 at cnt=5 while active=3 -> remainder of period follows 3, next period 12; write at cnt=15 -> new period directly 12.
REQ-035 Mode switch mid-period plus invalid write (wr_ch=4 on CHANNELS=4 build... use CHANNELS=3, wr_ch=3) -> mode change at next boundary only; no channel altered.
REQ-036 Enable drop at cnt=7 then re-raise -> outputs 0 while low, period_tick on first cycle after rise, count restarts at 0.
